delay_path_probe_ctrl: RTL and testbench

Sequencer that launches step transitions into a single-path delay chain and measures the propagation delay of each transition in clock cycles. It runs a programmed number of trials and reports the last and the averaged rising-edge delay. It also flags a dead or over-long path via timeout. It sits between the measurement register block and the delay-chain wrapper, driving the chain input and sampling the chain output.

---
 rtl/delay_path_probe_ctrl_pkg.sv | 17 +
 rtl/delay_path_probe_ctrl_sync.sv | 23 ++
 rtl/delay_path_probe_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_delay_path_probe_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/delay_path_probe_ctrl_pkg.sv
// Shared types and sizing helpers for the delay-path probe sequencer.
package delay_path_probe_ctrl_pkg;

    typedef enum logic [2:0] {
        stIdle    = 3'd0,
        stSettle  = 3'd1,
        stMeasure = 3'd2,
        stReturn  = 3'd3,
        stFinish  = 3'd4
    } probeState_t;

    // Accumulator width: one trial delay plus headroom for 2**trialsLog2 additions.
    function automatic int unsigned accWidth(input int unsigned cntW, input int unsigned trialsLog2);
        return cntW + trialsLog2;
    endfunction

endpackage

// File: rtl/delay_path_probe_ctrl_sync.sv
// probe_sync: STAGES-deep flop chain bringing the asynchronous path output into clk.
module probe_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/delay_path_probe_ctrl.sv
// Launches step transitions into a delay chain and measures rising-edge delay in cycles.
// Optional min/max delay outputs are enabled with `define PROBE_MINMAX_EN.
module delay_path_probe_ctrl
    import delay_path_probe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TRIALS_LOG2 = 3,
    parameter int unsigned TIMEOUT     = 1023,
    parameter int unsigned SETTLE      = 15,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             path_input,
    input  logic             path_result,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] delay_last,
    output logic [CNT_W-1:0] delay_avg
`ifdef PROBE_MINMAX_EN
    ,
    output logic [CNT_W-1:0] delay_min,
    output logic [CNT_W-1:0] delay_max
`endif
);

    localparam int unsigned ACC_W = accWidth(CNT_W, TRIALS_LOG2);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(SETTLE);

    probeState_t            state, stateNxt;
    logic [CNT_W-1:0]       settleCnt, settleNxt;
    logic [CNT_W-1:0]       cnt, cntNxt;
    logic [ACC_W-1:0]       acc, accNxt;
    logic [TRIALS_LOG2-1:0] trialIdx, trialNxt;
    logic                   errNxt;
    logic [CNT_W-1:0]       lastNxt, avgNxt;
    logic                   pathInNxt, busyNxt, doneNxt;
    logic                   rs;
`ifdef PROBE_MINMAX_EN
    logic [CNT_W-1:0]       minNxt, maxNxt;
`endif

    probe_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (path_result),
        .dout  (rs)
    );

    // State and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= stIdle;
            settleCnt   <= '0;
            cnt         <= '0;
            acc         <= '0;
            trialIdx    <= '0;
            path_input  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            delay_last  <= '0;
            delay_avg   <= '0;
`ifdef PROBE_MINMAX_EN
            delay_min   <= '1;
            delay_max   <= '0;
`endif
        end else begin
            state       <= stateNxt;
            settleCnt   <= settleNxt;
            cnt         <= cntNxt;
            acc         <= accNxt;
            trialIdx    <= trialNxt;
            path_input  <= pathInNxt;
            busy        <= busyNxt;
            done        <= doneNxt;
            timeout_err <= errNxt;
            delay_last  <= lastNxt;
            delay_avg   <= avgNxt;
`ifdef PROBE_MINMAX_EN
            delay_min   <= minNxt;
            delay_max   <= maxNxt;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        stateNxt  = state;
        settleNxt = settleCnt;
        cntNxt    = cnt;
        accNxt    = acc;
        trialNxt  = trialIdx;
        errNxt    = timeout_err;
        lastNxt   = delay_last;
        avgNxt    = delay_avg;
`ifdef PROBE_MINMAX_EN
        minNxt    = delay_min;
        maxNxt    = delay_max;
`endif

        case (state)
            stIdle: begin
                if (start) begin
                    accNxt    = '0;
                    trialNxt  = '0;
                    errNxt    = 1'b0;
                    settleNxt = '0;
                    cntNxt    = '0;
                    stateNxt  = stSettle;
`ifdef PROBE_MINMAX_EN
                    minNxt    = '1;
                    maxNxt    = '0;
`endif
                end
            end
            stSettle: begin
                // settleCnt tracks the low run; cnt tracks a stuck-high run.
                if (rs) begin
                    settleNxt = '0;
                    if (cnt == TIMEOUT_C) begin
                        errNxt   = 1'b1;
                        stateNxt = stFinish;
                    end else begin
                        cntNxt = cnt + CNT_W'(1);
                    end
                end else begin
                    cntNxt = '0;
                    if (settleCnt == SETTLE_C) begin
                        stateNxt = stMeasure;
                    end else begin
                        settleNxt = settleCnt + CNT_W'(1);
                    end
                end
            end
            stMeasure: begin
                if (rs) begin
                    lastNxt  = cnt;
                    accNxt   = acc + ACC_W'(cnt);
                    cntNxt   = '0;
                    stateNxt = stReturn;
`ifdef PROBE_MINMAX_EN
                    if (cnt < delay_min) minNxt = cnt;
                    if (cnt > delay_max) maxNxt = cnt;
`endif
                end else if (cnt == TIMEOUT_C) begin
                    errNxt   = 1'b1;
                    stateNxt = stFinish;
                end else begin
                    cntNxt = cnt + CNT_W'(1);
                end
            end
            stReturn: begin
                if (!rs) begin
                    trialNxt  = trialIdx + TRIALS_LOG2'(1);
                    settleNxt = '0;
                    cntNxt    = '0;
                    stateNxt  = (trialIdx == '1) ? stFinish : stSettle;
                end else if (cnt == TIMEOUT_C) begin
                    errNxt   = 1'b1;
                    stateNxt = stFinish;
                end else begin
                    cntNxt = cnt + CNT_W'(1);
                end
            end
            stFinish: begin
                stateNxt = stIdle;
            end
            default: begin
                stateNxt = stIdle;
            end
        endcase

        // Abort wins over any edge or timeout and leaves reported values untouched.
        if (abort && state != stIdle) begin
            stateNxt  = stIdle;
            settleNxt = settleCnt;
            cntNxt    = cnt;
            accNxt    = acc;
            trialNxt  = trialIdx;
            errNxt    = timeout_err;
            lastNxt   = delay_last;
`ifdef PROBE_MINMAX_EN
            minNxt    = delay_min;
            maxNxt    = delay_max;
`endif
        end

        if (stateNxt == stFinish && !errNxt) begin
            avgNxt = CNT_W'(accNxt >> TRIALS_LOG2);
        end

        pathInNxt = (stateNxt == stMeasure);
        busyNxt   = (stateNxt != stIdle);
        doneNxt   = (stateNxt == stFinish);
    end

endmodule

// File: tb/tb_delay_path_probe_ctrl.sv
// Scoreboard bench for delay_path_probe_ctrl with a transport-delay model of the chain.
// Min/max outputs are checked when PROBE_MINMAX_EN is defined.
module tb_delay_path_probe_ctrl;

    typedef struct packed {
        logic [15:0] last;
        logic [15:0] avg;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        path_input;
    logic        path_result;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [15:0] delay_last;
    logic [15:0] delay_avg;
`ifdef PROBE_MINMAX_EN
    logic [15:0] delay_min;
    logic [15:0] delay_max;
`endif

    int   nChecks = 0;
    int   nFails  = 0;
    exp_t sb[$];

    // Delay-chain model: transport delay of curDelay cycles, or a dead path.
    logic [15:0] hist = '0;
    logic        prevIn = 1'b0;
    int          curDelay = 6;
    int          delayTab[8];
    int          launchCnt = 0;
    int          launchBase = 0;
    int          doneCnt = 0;
    bit          pathDead = 1'b0;

    delay_path_probe_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .path_input  (path_input),
        .path_result (path_result),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .delay_last  (delay_last),
        .delay_avg   (delay_avg)
`ifdef PROBE_MINMAX_EN
        ,
        .delay_min   (delay_min),
        .delay_max   (delay_max)
`endif
    );

    always #5 clk = ~clk;

    assign path_result = pathDead ? 1'b0 : hist[curDelay-1];

    always @(posedge clk) begin
        prevIn <= path_input;
        hist   <= {hist[14:0], path_input};
        if (path_input && !prevIn) begin
            curDelay  <= delayTab[(launchCnt - launchBase) & 7];
            launchCnt <= launchCnt + 1;
        end
        if (done) doneCnt <= doneCnt + 1;
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic setDelays(input int first, input int step);
        for (int i = 0; i < 8; i++) delayTab[i] = first + i * step;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One full run: push expectation, launch, wait for done, pop and compare.
    task automatic doRun(input logic [15:0] expLast, input logic [15:0] expAvg,
                         input logic expErr, input int expLaunch, input bit midStart);
        exp_t e;
        int   doneBase;
        bit   got;
        e.last = expLast;
        e.avg  = expAvg;
        e.err  = expErr;
        sb.push_back(e);
        launchBase = launchCnt;
        doneBase   = doneCnt;
        pulseStart();
        checkEq("busy_after_start", 32'(busy), 32'd1);
        if (midStart) begin
            repeat (30) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        checkEq("done_seen", 32'(got), 32'd1);
        e = sb.pop_front();
        checkEq("delay_last", 32'(delay_last), 32'(e.last));
        checkEq("delay_avg", 32'(delay_avg), 32'(e.avg));
        checkEq("timeout_err", 32'(timeout_err), 32'(e.err));
        checkEq("path_input_at_done", 32'(path_input), 32'd0);
        // A start coincident with done must be ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkEq("busy_after_done", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        checkEq("busy_idle_hold", 32'(busy), 32'd0);
        checkEq("launch_count", 32'(launchCnt - launchBase), 32'(expLaunch));
        checkEq("done_count", 32'(doneCnt - doneBase), 32'd1);
    endtask

    initial begin
        int  seen;
        bit  lastPi;
        int  doneBase;

        setDelays(6, 0);
        #12;
        checkEq("rst_path_input", 32'(path_input), 32'd0);
        checkEq("rst_busy", 32'(busy), 32'd0);
        checkEq("rst_done", 32'(done), 32'd0);
        checkEq("rst_timeout_err", 32'(timeout_err), 32'd0);
        checkEq("rst_delay_last", 32'(delay_last), 32'd0);
        checkEq("rst_delay_avg", 32'(delay_avg), 32'd0);
`ifdef PROBE_MINMAX_EN
        checkEq("rst_delay_min", 32'(delay_min), 32'hFFFF);
        checkEq("rst_delay_max", 32'(delay_max), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Fixed 6-cycle path, with a stray start mid-run.
        doRun(16'd8, 16'd8, 1'b0, 8, 1'b1);

        // Varying path delays 3..10.
        setDelays(3, 1);
        repeat (20) @(negedge clk);
        doRun(16'd12, 16'd8, 1'b0, 8, 1'b0);
`ifdef PROBE_MINMAX_EN
        checkEq("delay_min", 32'(delay_min), 32'd5);
        checkEq("delay_max", 32'(delay_max), 32'd12);
`endif

        // Dead path: timeout in MEASURE, reported values kept.
        pathDead = 1'b1;
        doRun(16'd12, 16'd8, 1'b1, 1, 1'b0);
        pathDead = 1'b0;
        setDelays(6, 0);
        repeat (20) @(negedge clk);

        // Abort in the third MEASURE cycle of trial 2.
        launchBase = launchCnt;
        doneBase   = doneCnt;
        pulseStart();
        seen   = 0;
        lastPi = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (path_input && !lastPi) seen++;
            lastPi = path_input;
            if (seen == 2) break;
            @(negedge clk);
        end
        checkEq("abort_reached_trial2", 32'(seen), 32'd2);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkEq("abort_busy", 32'(busy), 32'd0);
        checkEq("abort_path_input", 32'(path_input), 32'd0);
        checkEq("abort_done", 32'(done), 32'd0);
        checkEq("abort_delay_last", 32'(delay_last), 32'd8);
        repeat (10) @(negedge clk);
        checkEq("abort_no_done", 32'(doneCnt - doneBase), 32'd0);
        checkEq("abort_stays_idle", 32'(busy), 32'd0);
        doRun(16'd8, 16'd8, 1'b0, 8, 1'b0);

        // Async reset while waiting in RETURN.
        pulseStart();
        seen   = 0;
        lastPi = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!path_input && lastPi) begin
                seen = 1;
                break;
            end
            lastPi = path_input;
        end
        checkEq("reached_return", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        checkEq("midrst_path_input", 32'(path_input), 32'd0);
        checkEq("midrst_busy", 32'(busy), 32'd0);
        checkEq("midrst_delay_last", 32'(delay_last), 32'd0);
        checkEq("midrst_delay_avg", 32'(delay_avg), 32'd0);
        checkEq("midrst_timeout_err", 32'(timeout_err), 32'd0);
`ifdef PROBE_MINMAX_EN
        checkEq("midrst_delay_min", 32'(delay_min), 32'hFFFF);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        doRun(16'd8, 16'd8, 1'b0, 8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
